uart: RTL and testbench

UART -- requirements
Module: uart

---
 rtl/uart.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_uart.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart.sv
// ---------------------------------------------------------------------------
// uart_fifo / uart
//
// Purpose: a small buffered UART. A free-running baud generator produces one
// tick every DVSR clocks (16 ticks per bit). The receiver oversamples a
// synchronized rx line and pushes each assembled byte into a 2^FIFO_W entry
// RX FIFO. The transmitter drains a 2^FIFO_W entry TX FIFO and serializes
// each byte LSB-first with one start bit and a stop period of SB_TICK ticks.
//
// uart ports:
//   CLK       in   sole clock, rising edge
//   RESET     in   synchronous, active-high reset
//   rd_uart   in   one-cycle pulse, pops the RX FIFO head
//   wr_uart   in   one-cycle pulse, pushes w_data into the TX FIFO
//   rx        in   serial receive line, idle high, asynchronous to CLK
//   w_data    in   [7:0] byte to transmit
//   tx_full   out  TX FIFO full
//   rx_empty  out  RX FIFO empty
//   tx        out  serial transmit line, idle high, registered
//   r_data    out  [7:0] RX FIFO head (first-word-fall-through)
//
// uart_fifo ports:
//   clk, reset          clock and synchronous active-high reset
//   rd, wr              pop / push requests
//   w_data              [DATA_W-1:0] push data
//   empty, full         occupancy flags
//   r_data              [DATA_W-1:0] current head, combinational
// ---------------------------------------------------------------------------

module uart_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd,
    input  logic              wr,
    input  logic [DATA_W-1:0] w_data,
    output logic              empty,
    output logic              full,
    output logic [DATA_W-1:0] r_data
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [ADDR_W-1:0] w_ptr_q, w_ptr_d;
    logic [ADDR_W-1:0] r_ptr_q, r_ptr_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic [ADDR_W-1:0] w_ptr_succ, r_ptr_succ;
    logic              do_push, do_pop;

    // Pointer and flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    // A pop from an empty FIFO is dropped, so a simultaneous push/pop on an
    // empty FIFO degenerates to a plain push. When full, a push is only
    // accepted together with a pop, which frees the slot being written.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        w_ptr_d    = w_ptr_q;
        r_ptr_d    = r_ptr_q;
        full_d     = full_q;
        empty_d    = empty_q;
        w_ptr_succ = w_ptr_q + ADDR_W'(1);
        r_ptr_succ = r_ptr_q + ADDR_W'(1);
        do_pop     = rd & ~empty_q;
        do_push    = wr & (~full_q | do_pop);

        if (do_push) begin
            mem_d[w_ptr_q] = w_data;
            w_ptr_d        = w_ptr_succ;
        end
        if (do_pop) begin
            r_ptr_d = r_ptr_succ;
        end

        if (do_push && !do_pop) begin
            empty_d = 1'b0;
            full_d  = (w_ptr_succ == r_ptr_q);
        end else if (do_pop && !do_push) begin
            full_d  = 1'b0;
            empty_d = (r_ptr_succ == w_ptr_q);
        end
    end

    assign empty  = empty_q;
    assign full   = full_q;
    assign r_data = mem_q[r_ptr_q];
endmodule


module uart #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR    = 163,
    parameter int FIFO_W  = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       rd_uart,
    input  logic       wr_uart,
    input  logic       rx,
    input  logic [7:0] w_data,
    output logic       tx_full,
    output logic       rx_empty,
    output logic       tx,
    output logic [7:0] r_data
);
    localparam int CNT_W = (DVSR > 1) ? $clog2(DVSR) : 1;

    // Shared by both FSMs; each keeps its own state register.
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // ------------------------------------------------------------------
    // Baud generator
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic             tick;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            baud_cnt_q <= '0;
        end else begin
            baud_cnt_q <= baud_cnt_d;
        end
    end

    always_comb begin
        tick       = (baud_cnt_q == CNT_W'(DVSR - 1));
        baud_cnt_d = tick ? '0 : baud_cnt_q + CNT_W'(1);
    end

    // ------------------------------------------------------------------
    // rx synchronizer. Resets to the idle level so the receiver does not
    // see a phantom start bit right after reset.
    // ------------------------------------------------------------------
    logic rx_meta_q, rx_meta_d;
    logic rx_sync_q, rx_sync_d;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_meta_d;
            rx_sync_q <= rx_sync_d;
        end
    end

    always_comb begin
        rx_meta_d = rx;
        rx_sync_d = rx_meta_q;
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    state_t            rx_state_q, rx_state_d;
    logic [3:0]        rx_s_q, rx_s_d;
    logic [2:0]        rx_n_q, rx_n_d;
    logic [DBIT-1:0]   rx_b_q, rx_b_d;
    logic              rx_done;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rx_state_q <= IDLE;
            rx_s_q     <= '0;
            rx_n_q     <= '0;
            rx_b_q     <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_s_q     <= rx_s_d;
            rx_n_q     <= rx_n_d;
            rx_b_q     <= rx_b_d;
        end
    end

    // START waits 8 ticks to land mid start bit; from there every 16 ticks
    // lands mid data bit. STOP ends SB_TICK ticks after the last data sample,
    // and the byte is stored without looking at the stop level.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_s_d     = rx_s_q;
        rx_n_d     = rx_n_q;
        rx_b_d     = rx_b_q;
        rx_done    = 1'b0;

        unique case (rx_state_q)
            IDLE: begin
                if (!rx_sync_q) begin
                    rx_state_d = START;
                    rx_s_d     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (rx_s_q == 4'd7) begin
                        if (rx_sync_q) begin
                            rx_state_d = IDLE;
                        end else begin
                            rx_state_d = DATA;
                            rx_s_d     = '0;
                            rx_n_d     = '0;
                        end
                    end else begin
                        rx_s_d = rx_s_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (rx_s_q == 4'd15) begin
                        rx_s_d = '0;
                        rx_b_d = {rx_sync_q, rx_b_q[DBIT-1:1]};
                        if (rx_n_q == 3'(DBIT - 1)) begin
                            rx_state_d = STOP;
                        end else begin
                            rx_n_d = rx_n_q + 3'd1;
                        end
                    end else begin
                        rx_s_d = rx_s_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (rx_s_q == 4'(SB_TICK - 1)) begin
                        rx_state_d = IDLE;
                        rx_done    = 1'b1;
                    end else begin
                        rx_s_d = rx_s_q + 4'd1;
                    end
                end
            end
            default: rx_state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    state_t            tx_state_q, tx_state_d;
    logic [3:0]        tx_s_q, tx_s_d;
    logic [2:0]        tx_n_q, tx_n_d;
    logic [DBIT-1:0]   tx_b_q, tx_b_d;
    logic              tx_q, tx_d;
    logic              tx_pop;
    logic              tx_fifo_empty;
    logic [7:0]        tx_fifo_head;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            tx_state_q <= IDLE;
            tx_s_q     <= '0;
            tx_n_q     <= '0;
            tx_b_q     <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_s_q     <= tx_s_d;
            tx_n_q     <= tx_n_d;
            tx_b_q     <= tx_b_d;
            tx_q       <= tx_d;
        end
    end

    // The end of STOP loads the next byte directly when one is waiting, so
    // back-to-back frames carry no idle cycle between them. The line level
    // is derived from the next state so tx changes together with the state.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_s_d     = tx_s_q;
        tx_n_d     = tx_n_q;
        tx_b_d     = tx_b_q;
        tx_pop     = 1'b0;
        tx_d       = 1'b1;

        unique case (tx_state_q)
            IDLE: begin
                if (!tx_fifo_empty) begin
                    tx_b_d     = DBIT'(tx_fifo_head);
                    tx_pop     = 1'b1;
                    tx_s_d     = '0;
                    tx_state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    if (tx_s_q == 4'd15) begin
                        tx_state_d = DATA;
                        tx_s_d     = '0;
                        tx_n_d     = '0;
                    end else begin
                        tx_s_d = tx_s_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tx_s_q == 4'd15) begin
                        tx_s_d = '0;
                        tx_b_d = tx_b_q >> 1;
                        if (tx_n_q == 3'(DBIT - 1)) begin
                            tx_state_d = STOP;
                        end else begin
                            tx_n_d = tx_n_q + 3'd1;
                        end
                    end else begin
                        tx_s_d = tx_s_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (tx_s_q == 4'(SB_TICK - 1)) begin
                        if (!tx_fifo_empty) begin
                            tx_b_d     = DBIT'(tx_fifo_head);
                            tx_pop     = 1'b1;
                            tx_s_d     = '0;
                            tx_state_d = START;
                        end else begin
                            tx_state_d = IDLE;
                        end
                    end else begin
                        tx_s_d = tx_s_q + 4'd1;
                    end
                end
            end
            default: tx_state_d = IDLE;
        endcase

        unique case (tx_state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = tx_b_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign tx = tx_q;

    // ------------------------------------------------------------------
    // FIFOs
    // ------------------------------------------------------------------
    logic rx_fifo_full_unused;

    uart_fifo #(
        .DATA_W (8),
        .ADDR_W (FIFO_W)
    ) u_rx_fifo (
        .clk    (CLK),
        .reset  (RESET),
        .rd     (rd_uart),
        .wr     (rx_done),
        .w_data (8'(rx_b_q)),
        .empty  (rx_empty),
        .full   (rx_fifo_full_unused),
        .r_data (r_data)
    );

    uart_fifo #(
        .DATA_W (8),
        .ADDR_W (FIFO_W)
    ) u_tx_fifo (
        .clk    (CLK),
        .reset  (RESET),
        .rd     (tx_pop),
        .wr     (wr_uart),
        .w_data (w_data),
        .empty  (tx_fifo_empty),
        .full   (tx_full),
        .r_data (tx_fifo_head)
    );
endmodule

// File: tb/tb_uart.sv
// ---------------------------------------------------------------------------
// tb_uart
//
// Purpose: self-checking bench for uart. Uses a short baud divisor so whole
// frames fit in a few thousand cycles. Bytes written to the transmitter and
// bytes driven onto rx are pushed into scoreboard queues as they are sent
// and popped when the DUT presents them on tx or r_data.
// ---------------------------------------------------------------------------

module tb_uart;
    localparam int DBIT     = 8;
    localparam int SB_TICK  = 16;
    localparam int DVSR     = 5;
    localparam int FIFO_W   = 2;
    localparam int BIT_CLKS = 16 * DVSR;

    logic       clk = 1'b0;
    logic       reset;
    logic       rd_uart;
    logic       wr_uart;
    logic       rx;
    logic [7:0] w_data;
    logic       tx_full;
    logic       rx_empty;
    logic       tx;
    logic [7:0] r_data;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] tx_sb [$];
    logic [7:0] rx_sb [$];

    // 2-unit clock period; inputs are driven and outputs sampled on negedge.
    always #1 clk = ~clk;

    uart #(
        .DBIT    (DBIT),
        .SB_TICK (SB_TICK),
        .DVSR    (DVSR),
        .FIFO_W  (FIFO_W)
    ) dut (
        .CLK      (clk),
        .RESET    (reset),
        .rd_uart  (rd_uart),
        .wr_uart  (wr_uart),
        .rx       (rx),
        .w_data   (w_data),
        .tx_full  (tx_full),
        .rx_empty (rx_empty),
        .tx       (tx),
        .r_data   (r_data)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One-cycle pulse on the host-side controls.
    task automatic applyStimulus(input logic wr, input logic rd, input logic [7:0] data);
        wr_uart = wr;
        rd_uart = rd;
        w_data  = data;
        step(1);
        wr_uart = 1'b0;
        rd_uart = 1'b0;
    endtask

    task automatic writeByte(input logic [7:0] data);
        tx_sb.push_back(data);
        applyStimulus(1'b1, 1'b0, data);
    endtask

    // Drives a start bit and the first nbits data bits; a full frame also
    // gets its stop bit and is expected back from the RX FIFO.
    task automatic sendRxBits(input logic [7:0] data, input int nbits);
        rx = 1'b0;
        step(BIT_CLKS);
        for (int i = 0; i < nbits; i++) begin
            rx = data[i];
            step(BIT_CLKS);
        end
        if (nbits == DBIT) begin
            rx_sb.push_back(data);
            rx = 1'b1;
            step(BIT_CLKS);
        end
    endtask

    task automatic checkRxHead(input string tag);
        logic [7:0] exp_byte;
        if (rx_sb.size() == 0) begin
            checkOutput({tag, " scoreboard empty"}, 16'(r_data), 16'hFFFF);
        end else begin
            exp_byte = rx_sb.pop_front();
            checkOutput(tag, 16'(r_data), 16'(exp_byte));
        end
    endtask

    // Finds the start edge, then samples each bit near its centre. A gap
    // limit above zero also checks how soon the frame followed the last one.
    task automatic recvTxFrame(input string tag, input int max_gap);
        int         waited;
        logic       start_bit;
        logic       stop_bit;
        logic [7:0] got;
        logic [7:0] exp_byte;
        waited = 0;
        while (tx !== 1'b0 && waited < 40 * BIT_CLKS) begin
            step(1);
            waited++;
        end
        if (tx !== 1'b0) begin
            checkOutput({tag, " start timeout"}, 16'(tx), 16'h0);
            return;
        end
        if (max_gap > 0) begin
            checkOutput({tag, " gap"}, 16'(waited <= max_gap), 16'h1);
        end
        step(BIT_CLKS / 2);
        start_bit = tx;
        for (int i = 0; i < DBIT; i++) begin
            step(BIT_CLKS);
            got[i] = tx;
        end
        step(BIT_CLKS);
        stop_bit = tx;
        checkOutput({tag, " start bit"}, 16'(start_bit), 16'h0);
        checkOutput({tag, " stop bit"}, 16'(stop_bit), 16'h1);
        if (tx_sb.size() == 0) begin
            checkOutput({tag, " scoreboard empty"}, 16'(got), 16'hFFFF);
        end else begin
            exp_byte = tx_sb.pop_front();
            checkOutput({tag, " data"}, 16'(got), 16'(exp_byte));
        end
    endtask

    initial begin
        logic idle_ok;

        reset   = 1'b1;
        rd_uart = 1'b0;
        wr_uart = 1'b0;
        rx      = 1'b1;
        w_data  = 8'h00;
        step(3);
        reset = 1'b0;
        step(1);

        checkOutput("reset tx", 16'(tx), 16'h1);
        checkOutput("reset rx_empty", 16'(rx_empty), 16'h1);
        checkOutput("reset tx_full", 16'(tx_full), 16'h0);

        idle_ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (tx !== 1'b1 || rx_empty !== 1'b1 || tx_full !== 1'b0) idle_ok = 1'b0;
        end
        checkOutput("idle 100 cycles", 16'(idle_ok), 16'h1);

        // Single transmit of 0x55.
        writeByte(8'h55);
        checkOutput("tx_full after one write", 16'(tx_full), 16'h0);
        recvTxFrame("tx 0x55", 0);
        checkOutput("tx_full during 0x55", 16'(tx_full), 16'h0);
        step(BIT_CLKS);
        checkOutput("tx idle after 0x55", 16'(tx), 16'h1);

        // Two received frames, then a read.
        sendRxBits(8'h55, DBIT);
        checkOutput("rx_empty after first rx frame", 16'(rx_empty), 16'h0);
        sendRxBits(8'h5F, DBIT);
        step(4);
        checkOutput("rx_empty before read", 16'(rx_empty), 16'h0);
        checkRxHead("r_data before read");
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("rx_empty after read", 16'(rx_empty), 16'h0);
        checkRxHead("r_data after read");
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("rx_empty after draining", 16'(rx_empty), 16'h1);

        // A short low pulse is rejected as a false start.
        rx = 1'b0;
        step(3 * DVSR);
        rx = 1'b1;
        step(2 * BIT_CLKS);
        checkOutput("glitch rejected rx_empty", 16'(rx_empty), 16'h1);

        // Burst of five writes; the sixth arrives while full and is dropped.
        writeByte(8'hA1);
        writeByte(8'hB2);
        writeByte(8'hC3);
        writeByte(8'hD4);
        writeByte(8'hE5);
        checkOutput("tx_full after burst", 16'(tx_full), 16'h1);
        applyStimulus(1'b1, 1'b0, 8'h66);
        checkOutput("tx_full after dropped write", 16'(tx_full), 16'h1);
        recvTxFrame("burst 0", 0);
        recvTxFrame("burst 1", BIT_CLKS / 2 + 2);
        recvTxFrame("burst 2", BIT_CLKS / 2 + 2);
        recvTxFrame("burst 3", BIT_CLKS / 2 + 2);
        recvTxFrame("burst 4", BIT_CLKS / 2 + 2);
        idle_ok = 1'b1;
        for (int i = 0; i < 2 * BIT_CLKS; i++) begin
            step(1);
            if (tx !== 1'b1) idle_ok = 1'b0;
        end
        checkOutput("no frame for dropped write", 16'(idle_ok), 16'h1);
        checkOutput("tx_full after burst drained", 16'(tx_full), 16'h0);

        // Reset in the middle of a reception, then a clean 0xA3.
        sendRxBits(8'hFF, 3);
        rx = 1'b1;
        step(BIT_CLKS / 2);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(BIT_CLKS);
        checkOutput("rx_empty after mid-frame reset", 16'(rx_empty), 16'h1);
        sendRxBits(8'hA3, DBIT);
        step(4);
        checkOutput("rx_empty after 0xA3", 16'(rx_empty), 16'h0);
        checkRxHead("r_data 0xA3");
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("only one byte after reset", 16'(rx_empty), 16'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
